// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: register/data widths,
// the PC register index and the queued aux-write entry format.
package regfile_write_arbiter_pkg;

  localparam int unsigned REG_NUM_W = 4;
  localparam int unsigned DATA_W    = 32;

  localparam logic [REG_NUM_W-1:0] REG_PC = 4'd15;

  typedef struct packed {
    logic                 kill;
    logic [REG_NUM_W-1:0] num;
    logic [DATA_W-1:0]    data;
  } aux_entry_t;

  function automatic logic [15:0] reg_onehot(input logic [REG_NUM_W-1:0] n);
    logic [15:0] r;
    r    = '0;
    r[n] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of the writeback, aux request and register-file port signals.
// master drives the requests, slave is the arbiter.
interface regfile_write_arbiter_if;
  import regfile_write_arbiter_pkg::*;

  logic                 wb_write;
  logic [REG_NUM_W-1:0] wb_num;
  logic [DATA_W-1:0]    wb_data;
  logic                 aux_valid;
  logic                 aux_ready;
  logic [REG_NUM_W-1:0] aux_num;
  logic [DATA_W-1:0]    aux_data;
  logic                 regfile_write;
  logic [REG_NUM_W-1:0] regfile_write_reg;
  logic [DATA_W-1:0]    regfile_write_data;
  logic                 jmp;
  logic [DATA_W-1:0]    jmppc;
  logic                 pipe_stall;
  logic [15:0]          pending_mask;

  modport master (
    output wb_write, wb_num, wb_data, aux_valid, aux_num, aux_data,
    input  aux_ready, regfile_write, regfile_write_reg, regfile_write_data,
           jmp, jmppc, pipe_stall, pending_mask
  );

  modport slave (
    input  wb_write, wb_num, wb_data, aux_valid, aux_num, aux_data,
    output aux_ready, regfile_write, regfile_write_reg, regfile_write_data,
           jmp, jmppc, pipe_stall, pending_mask
  );

endinterface

// File: rtl/regfile_write_arbiter_aux_write_fifo.sv
// Small FIFO of pending aux register writes; every valid entry whose
// destination matches kill_tag is marked killed when kill_en is set.
module aux_write_fifo
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  aux_entry_t                   push_entry,
  input  logic                         pop,
  input  logic                         kill_en,
  input  logic [REG_NUM_W-1:0]         kill_tag,
  output aux_entry_t                   head,
  output logic                         full,
  output logic                         empty,
  output logic [DEPTH-1:0]             live_vec,
  output logic [DEPTH*REG_NUM_W-1:0]   num_vec
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  aux_entry_t       mem_q [DEPTH];
  aux_entry_t       mem_d [DEPTH];

  // Entries are contiguous, so the slot under each pointer tells full/empty.
  assign head  = mem_q[rd_ptr_q];
  assign empty = !valid_q[rd_ptr_q];
  assign full  = valid_q[wr_ptr_q];

  always_comb begin
    live_vec = '0;
    num_vec  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      live_vec[i]                     = valid_q[i] && !mem_q[i].kill;
      num_vec[i*REG_NUM_W +: REG_NUM_W] = mem_q[i].num;
    end
  end

  always_comb begin
    mem_d    = mem_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (kill_en && valid_q[i] && (mem_q[i].num == kill_tag)) begin
        mem_d[i].kill = 1'b1;
      end
    end
    if (pop && !empty) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end
    if (push && !full) begin
      mem_d[wr_ptr_q]   = push_entry;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between the writeback pipeline (priority)
// and a queued aux requester, with kill-on-overwrite and starvation stall.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  regfile_write_arbiter_if.slave  bus
);

  localparam int unsigned     CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  aux_entry_t                 head;
  aux_entry_t                 push_entry;
  logic                       full;
  logic                       empty;
  logic [DEPTH-1:0]           live_vec;
  logic [DEPTH*REG_NUM_W-1:0] num_vec;

  logic pipe_wr;
  logic port_free;
  logic head_dead;
  logic head_live;
  logic head_is_pc;
  logic aux_wr;
  logic aux_jmp;
  logic pop;
  logic push;

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             pipe_stall_q, pipe_stall_d;

  assign pipe_wr    = bus.wb_write && (bus.wb_num != REG_PC);
  assign port_free  = !pipe_wr;
  // The concurrent pipeline write is younger, so it kills a matching head now.
  assign head_dead  = head.kill || (bus.wb_write && (bus.wb_num == head.num));
  assign head_live  = !empty && !head_dead;
  assign head_is_pc = (head.num == REG_PC);
  assign aux_wr     = head_live && !head_is_pc && port_free;
  assign aux_jmp    = head_live && head_is_pc;
  assign pop        = !empty && (head_dead || head_is_pc || port_free);
  assign push       = bus.aux_valid && !full;

  always_comb begin
    push_entry      = '0;
    push_entry.kill = bus.wb_write && (bus.aux_num == bus.wb_num);
    push_entry.num  = bus.aux_num;
    push_entry.data = bus.aux_data;
  end

  aux_write_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .kill_en    (bus.wb_write),
    .kill_tag   (bus.wb_num),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .live_vec   (live_vec),
    .num_vec    (num_vec)
  );

  always_comb begin
    bus.regfile_write      = 1'b0;
    bus.regfile_write_reg  = '0;
    bus.regfile_write_data = '0;
    bus.jmp                = 1'b0;
    bus.jmppc              = '0;
    bus.aux_ready          = 1'b0;
    bus.pending_mask       = '0;
    if (!rst) begin
      bus.aux_ready = !full;
      if (pipe_wr) begin
        bus.regfile_write      = 1'b1;
        bus.regfile_write_reg  = bus.wb_num;
        bus.regfile_write_data = bus.wb_data;
      end else if (aux_wr) begin
        bus.regfile_write      = 1'b1;
        bus.regfile_write_reg  = head.num;
        bus.regfile_write_data = head.data;
      end
      if (aux_jmp) begin
        bus.jmp   = 1'b1;
        bus.jmppc = head.data;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (live_vec[i]) begin
          bus.pending_mask = bus.pending_mask | reg_onehot(num_vec[i*REG_NUM_W +: REG_NUM_W]);
        end
      end
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (empty || pop) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
    pipe_stall_d = (wait_cnt_d == WAIT_MAX);
  end

  assign bus.pipe_stall = pipe_stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q   <= '0;
      pipe_stall_q <= 1'b0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      pipe_stall_q <= pipe_stall_d;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench: a queue-level model of the arbiter is checked against the DUT
// every cycle, with hand-computed literal checks along the test plan.
module tb_regfile_write_arbiter;

  localparam int unsigned DEPTH    = 2;
  localparam int unsigned MAX_WAIT = 4;

  typedef struct {
    logic [3:0]  num;
    logic [31:0] data;
    bit          kill;
  } ent_t;

  logic clk;
  logic rst;
  regfile_write_arbiter_if bus ();

  regfile_write_arbiter #(
    .DEPTH    (DEPTH),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   tests;
  int   fails;
  ent_t mq[$];
  int   mwait;
  bit   mstall;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    mwait  = 0;
    mstall = 0;
  endtask

  task automatic drive(input bit w, input logic [3:0] wn, input logic [31:0] wd,
                       input bit av, input logic [3:0] an, input logic [31:0] ad);
    bus.wb_write  = w;
    bus.wb_num    = wn;
    bus.wb_data   = wd;
    bus.aux_valid = av;
    bus.aux_num   = an;
    bus.aux_data  = ad;
  endtask

  // Compare every DUT output against the model at the falling edge.
  task automatic sample();
    bit          e_wr, e_jmp, e_ready, pipe, dead, have;
    logic [3:0]  e_reg;
    logic [31:0] e_data, e_pc;
    logic [15:0] e_mask;
    @(negedge clk);
    if (rst) model_clear();
    e_wr = 0; e_jmp = 0; e_ready = 0; e_reg = '0; e_data = '0; e_pc = '0; e_mask = '0;
    if (!rst) begin
      pipe    = bus.wb_write && (bus.wb_num != 4'd15);
      have    = (mq.size() != 0);
      dead    = have && (mq[0].kill || (bus.wb_write && bus.wb_num == mq[0].num));
      e_ready = (mq.size() < DEPTH);
      if (pipe) begin
        e_wr = 1; e_reg = bus.wb_num; e_data = bus.wb_data;
      end else if (have && !dead && mq[0].num != 4'd15) begin
        e_wr = 1; e_reg = mq[0].num; e_data = mq[0].data;
      end
      if (have && !dead && mq[0].num == 4'd15) begin
        e_jmp = 1; e_pc = mq[0].data;
      end
      foreach (mq[i]) if (!mq[i].kill) e_mask[mq[i].num] = 1'b1;
    end
    chk("model regfile_write", 32'(bus.regfile_write), 32'(e_wr));
    if (e_wr) begin
      chk("model regfile_write_reg", 32'(bus.regfile_write_reg), 32'(e_reg));
      chk("model regfile_write_data", bus.regfile_write_data, e_data);
    end
    chk("model jmp", 32'(bus.jmp), 32'(e_jmp));
    chk("model jmppc", bus.jmppc, e_pc);
    chk("model aux_ready", 32'(bus.aux_ready), 32'(e_ready));
    chk("model pending_mask", 32'(bus.pending_mask), 32'(e_mask));
    chk("model pipe_stall", 32'(bus.pipe_stall), 32'(mstall));
  endtask

  // Advance the model across the rising edge, then move to the drive point.
  task automatic adv();
    bit   pre_full, pre_empty, pipe, popped;
    ent_t e;
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      pre_full  = (mq.size() >= DEPTH);
      pre_empty = (mq.size() == 0);
      pipe      = bus.wb_write && (bus.wb_num != 4'd15);
      popped    = 0;
      foreach (mq[i]) if (bus.wb_write && mq[i].num == bus.wb_num) mq[i].kill = 1;
      if (!pre_empty && (mq[0].kill || mq[0].num == 4'd15 || !pipe)) begin
        void'(mq.pop_front());
        popped = 1;
      end
      if (bus.aux_valid && !pre_full) begin
        e.num  = bus.aux_num;
        e.data = bus.aux_data;
        e.kill = bus.wb_write && (bus.aux_num == bus.wb_num);
        mq.push_back(e);
      end
      if (pre_empty || popped) mwait = 0;
      else if (mwait < MAX_WAIT) mwait++;
      mstall = (mwait == MAX_WAIT);
    end
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    model_clear();
    rst = 1'b1;
    drive(1, 4'd3, 32'hDEAD0003, 1, 4'd5, 32'h5);

    // Reset holds every output low, even with requests present.
    sample();
    chk("rst regfile_write", 32'(bus.regfile_write), 32'd0);
    chk("rst aux_ready", 32'(bus.aux_ready), 32'd0);
    chk("rst pending_mask", 32'(bus.pending_mask), 32'd0);
    chk("rst pipe_stall", 32'(bus.pipe_stall), 32'd0);
    adv();
    sample(); adv();
    rst = 1'b0;

    // Pipeline only.
    drive(1, 4'd3, 32'hDEAD0003, 0, 4'd0, 32'h0);
    sample();
    chk("pipe write", 32'(bus.regfile_write), 32'd1);
    chk("pipe reg", 32'(bus.regfile_write_reg), 32'd3);
    chk("pipe data", bus.regfile_write_data, 32'hDEAD0003);
    chk("pipe aux_ready", 32'(bus.aux_ready), 32'd1);
    chk("pipe pending", 32'(bus.pending_mask), 32'd0);
    adv();

    // Idle drain of aux r5.
    drive(0, 4'd0, 32'h0, 1, 4'd5, 32'h55);
    sample();
    chk("drain push-cycle write", 32'(bus.regfile_write), 32'd0);
    chk("drain push-cycle pending", 32'(bus.pending_mask), 32'd0);
    adv();
    drive(0, 4'd0, 32'h0, 0, 4'd0, 32'h0);
    sample();
    chk("drain write", 32'(bus.regfile_write), 32'd1);
    chk("drain reg", 32'(bus.regfile_write_reg), 32'd5);
    chk("drain data", bus.regfile_write_data, 32'h55);
    chk("drain pending", 32'(bus.pending_mask), 32'h0020);
    adv();
    sample();
    chk("drain after pending", 32'(bus.pending_mask), 32'd0);
    chk("drain after write", 32'(bus.regfile_write), 32'd0);
    adv();

    // Cancel: queued r7 overwritten by the pipeline.
    drive(1, 4'd1, 32'h11, 1, 4'd7, 32'h77);
    sample(); adv();
    drive(1, 4'd7, 32'h99, 0, 4'd0, 32'h0);
    sample();
    chk("cancel reg", 32'(bus.regfile_write_reg), 32'd7);
    chk("cancel data", bus.regfile_write_data, 32'h99);
    chk("cancel pending before", 32'(bus.pending_mask), 32'h0080);
    adv();
    drive(0, 4'd0, 32'h0, 0, 4'd0, 32'h0);
    sample();
    chk("cancel no second write", 32'(bus.regfile_write), 32'd0);
    chk("cancel pending after", 32'(bus.pending_mask), 32'd0);
    adv();

    // Same-cycle push to the register being written is stored killed.
    drive(1, 4'd8, 32'h1, 1, 4'd8, 32'h88);
    sample();
    chk("samekill data", bus.regfile_write_data, 32'h1);
    adv();
    drive(0, 4'd0, 32'h0, 0, 4'd0, 32'h0);
    sample();
    chk("samekill no write", 32'(bus.regfile_write), 32'd0);
    adv();

    // Pipeline r15 kills a queued r15: neither port nor jump used.
    drive(1, 4'd1, 32'h11, 1, 4'd15, 32'h100);
    sample(); adv();
    drive(1, 4'd15, 32'h200, 0, 4'd0, 32'h0);
    sample();
    chk("pc kill write", 32'(bus.regfile_write), 32'd0);
    chk("pc kill jmp", 32'(bus.jmp), 32'd0);
    chk("pc kill pending", 32'(bus.pending_mask), 32'h8000);
    adv();
    drive(0, 4'd0, 32'h0, 0, 4'd0, 32'h0);
    sample();
    chk("pc kill after jmp", 32'(bus.jmp), 32'd0);
    adv();

    // Starvation: r2 held behind four busy cycles.
    drive(1, 4'd1, 32'h1, 1, 4'd2, 32'h22);
    sample(); adv();
    drive(1, 4'd1, 32'h1, 0, 4'd0, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      sample();
      chk("starve no stall yet", 32'(bus.pipe_stall), 32'd0);
      adv();
    end
    drive(0, 4'd0, 32'h0, 0, 4'd0, 32'h0);
    sample();
    chk("starve stall", 32'(bus.pipe_stall), 32'd1);
    chk("starve drain reg", 32'(bus.regfile_write_reg), 32'd2);
    chk("starve drain data", bus.regfile_write_data, 32'h22);
    adv();
    sample();
    chk("starve stall drop", 32'(bus.pipe_stall), 32'd0);
    adv();

    // Full FIFO and aux jump.
    drive(1, 4'd1, 32'h1, 1, 4'd4, 32'h44);
    sample(); adv();
    drive(1, 4'd1, 32'h1, 1, 4'd15, 32'h8000);
    sample(); adv();
    drive(1, 4'd1, 32'h1, 1, 4'd6, 32'h66);
    sample();
    chk("full aux_ready", 32'(bus.aux_ready), 32'd0);
    chk("full pending", 32'(bus.pending_mask), 32'h8010);
    adv();
    drive(0, 4'd0, 32'h0, 1, 4'd6, 32'h66);
    sample();
    chk("full pop-cycle ready", 32'(bus.aux_ready), 32'd0);
    chk("full drain r4", 32'(bus.regfile_write_reg), 32'd4);
    adv();
    drive(0, 4'd0, 32'h0, 0, 4'd0, 32'h0);
    sample();
    chk("auxjmp jmp", 32'(bus.jmp), 32'd1);
    chk("auxjmp pc", bus.jmppc, 32'h8000);
    chk("auxjmp no write", 32'(bus.regfile_write), 32'd0);
    adv();
    sample();
    chk("ignored push write", 32'(bus.regfile_write), 32'd0);
    chk("ignored push jmppc", bus.jmppc, 32'd0);
    adv();

    // Reset mid-operation with two entries queued and stall raised.
    drive(1, 4'd1, 32'h1, 1, 4'd10, 32'hA);
    sample(); adv();
    drive(1, 4'd1, 32'h1, 1, 4'd11, 32'hB);
    sample(); adv();
    drive(1, 4'd1, 32'h1, 0, 4'd0, 32'h0);
    for (int i = 2; i <= 4; i++) begin
      sample(); adv();
    end
    sample();
    chk("midrst stall before", 32'(bus.pipe_stall), 32'd1);
    chk("midrst full before", 32'(bus.aux_ready), 32'd0);
    adv();
    rst = 1'b1;
    sample();
    chk("midrst write", 32'(bus.regfile_write), 32'd0);
    chk("midrst stall", 32'(bus.pipe_stall), 32'd0);
    chk("midrst pending", 32'(bus.pending_mask), 32'd0);
    adv();
    rst = 1'b0;
    drive(0, 4'd0, 32'h0, 0, 4'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("postrst no old write", 32'(bus.regfile_write), 32'd0);
      chk("postrst ready", 32'(bus.aux_ready), 32'd1);
      adv();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single register-file write port between the in-order writeback path (highest priority, zero latency) and an auxiliary late-completing requester, such as a multi-cycle load/LDM return unit. Auxiliary writes are buffered in a small FIFO and drained into idle port slots. A queued write is cancelled when the pipeline later writes the same register. A starvation counter forces a pipeline bubble, and a 16-bit pending mask feeds decode interlock. Sits between Writeback's regfile outputs and the register file.

Parameters:
DEPTH, 2, aux FIFO entries; power of two, >=2
MAX_WAIT, 4, cycles a live head may wait before pipe_stall asserts; >=1

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
wb_write  in  1  pipeline write request, already bubble-qualified
wb_num  in  4  pipeline destination register
wb_data  in  32  pipeline write data
aux_valid  in  1  aux request valid
aux_ready  out  1  aux request accepted when valid&&ready
aux_num  in  4  aux destination register
aux_data  in  32  aux write data
regfile_write  out  1  register-file write enable
regfile_write_reg  out  4  register-file write address
regfile_write_data  out  32  register-file write data
jmp  out  1  aux write to r15 drained; one-cycle pulse
jmppc  out  32  jump target; 0 when jmp=0
pipe_stall  out  1  upstream must issue a bubble next cycle (registered)
pending_mask  out  16  one-hot OR of live queued destinations

Behaviour:
- Reset (async assert): FIFO emptied, kill bits cleared, wait_cnt=0, pipe_stall=0. While rst=1: regfile_write=0, jmp=0, jmppc=0, aux_ready=0, pending_mask=0.
- Port outputs are combinational from the current inputs and the FIFO head. State updates on posedge clk.
- Pipeline priority: wb_write && wb_num!=15 -> regfile_write=1, reg/data = wb_num/wb_data, in the same cycle. A pipeline write to r15 does not use the port; Writeback handles that jump.
- port_free = !(wb_write && wb_num!=15).
- Ordering: aux data is always older than the concurrent pipeline write. On wb_write, every queued entry with num==wb_num sets its kill bit. An entry pushed in the same cycle with aux_num==wb_num is stored already killed. This rule also applies to r15.
- Head processing, at most one pop per cycle:
  - Killed head: popped without any write, regardless of port_free.
  - Live head, num!=15, port_free: regfile_write=1, reg/data from the head; pop.
  - Live head, num==15: jmp=1, jmppc=head data, no regfile write; pop. Needs no port. It is never blocked by a pipeline r15 write, because that write kills the entry first.
  - Otherwise the head is held.
- Kill-bit check: a live head is evaluated against the kill bits after the current wb_write is applied. If wb_num matches the head, the head is treated as killed in that same cycle and is not written.
- aux_ready = !full, using pre-update occupancy. A full FIFO accepts no push in the same cycle it pops.
- Push and pop may occur in the same cycle when not full; occupancy is unchanged. Pointers wrap modulo DEPTH.
- wait_cnt behaviour:
  - Increments each cycle a live head is held, saturating at MAX_WAIT.
  - Clears on any pop and when the FIFO is empty.
  - pipe_stall <= (wait_cnt_next == MAX_WAIT).
  - Upstream must present wb_write=0 in the following cycle; the head then drains and pipe_stall drops the cycle after.
- pending_mask: bit n=1 iff a live (unkilled) queued entry has num==n. Computed from registered state, so it excludes the same-cycle push.

Decomposition:
- Shared core package: REG_PC=4'd15, REG_NUM_W=4, DATA_W=32.
- Sub-module aux_write_fifo (DEPTH entries of {kill, num, data}; push, pop, kill_match port with 4-bit tag, head, full, empty, per-entry live/num vectors for pending_mask).
- Arbitration, starvation counter and output muxing stay in the top module.

Test Plan:
- Pipeline only: wb_write=1, wb_num=3, wb_data=0xDEAD0003 -> same cycle regfile_write=1, reg=3, data=0xDEAD0003. aux_ready=1, pending_mask=0.
- Idle drain: push aux r5=0x55 with wb_write=0 -> next cycle regfile_write=1, reg=5, data=0x55. pending_mask bit5 set for exactly one cycle.
- Cancel: push aux r7=0x77, then a pipeline write r7=0x99 -> only 0x99 written. Entry popped silently, pending_mask bit7 clears, no second write.
- Starvation, MAX_WAIT=4: aux r2 queued, wb_write=1 to r1 every cycle -> pipe_stall=1 after the 4th blocked cycle. Bench bubbles; r2 written; pipe_stall=0 the cycle after.
- Full/aux jump, DEPTH=2: two pushes with the port busy -> aux_ready=0; third push ignored. Aux r15=0x8000 drains -> jmp=1, jmppc=0x8000, regfile_write=0 for that entry.
- Reset mid-operation: rst asserted with 2 entries queued and pipe_stall=1 -> all outputs zero immediately. After release, FIFO empty and none of the old entries are written.
